// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared types and constants for the BCD event counter and its seven-segment
// scan driver.
//   bcd_digit_t        : one BCD digit (values 0..9 only)
//   GLYPH_0..GLYPH_9   : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   GLYPH_BLANK        : all segments off
//   DEFAULT_NUM_DIGITS : default digit count of counter and display
// -----------------------------------------------------------------------------
package counter_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam int DEFAULT_NUM_DIGITS = 4;

   localparam logic [6:0] GLYPH_0     = 7'b1000000;
   localparam logic [6:0] GLYPH_1     = 7'b1111001;
   localparam logic [6:0] GLYPH_2     = 7'b0100100;
   localparam logic [6:0] GLYPH_3     = 7'b0110000;
   localparam logic [6:0] GLYPH_4     = 7'b0011001;
   localparam logic [6:0] GLYPH_5     = 7'b0010010;
   localparam logic [6:0] GLYPH_6     = 7'b0000010;
   localparam logic [6:0] GLYPH_7     = 7'b1111000;
   localparam logic [6:0] GLYPH_8     = 7'b0000000;
   localparam logic [6:0] GLYPH_9     = 7'b0010000;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

   // Codes 10..15 never occur in the counter; blank them rather than guess.
   function automatic logic [6:0] seg7_decode(input bcd_digit_t d);
      case (d)
         4'd0:    return GLYPH_0;
         4'd1:    return GLYPH_1;
         4'd2:    return GLYPH_2;
         4'd3:    return GLYPH_3;
         4'd4:    return GLYPH_4;
         4'd5:    return GLYPH_5;
         4'd6:    return GLYPH_6;
         4'd7:    return GLYPH_7;
         4'd8:    return GLYPH_8;
         4'd9:    return GLYPH_9;
         default: return GLYPH_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Time-multiplexes a packed BCD value onto a common-anode seven-segment display.
// Each digit is lit for SCAN_DIV cycles, scanning digit 0 upward.
//   i_clk       : clock, rising edge
//   i_rst       : asynchronous active-high reset
//   i_count_bcd : 4*NUM_DIGITS packed BCD, digit 0 in [3:0]
//   o_seg_n     : registered active-low segments {g,f,e,d,c,b,a}
//   o_an_n      : registered active-low digit enables, one-hot-low
// -----------------------------------------------------------------------------
module seg7_scan
   import counter_pkg::*;
#(
   parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
   parameter int SCAN_DIV   = 100000
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [4*NUM_DIGITS-1:0] i_count_bcd,
   output logic [6:0]              o_seg_n,
   output logic [NUM_DIGITS-1:0]   o_an_n
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CNT_W-1:0]      r_scan_cnt;
   logic [IDX_W-1:0]      r_scan_idx;
   logic [6:0]            r_seg_n;
   logic [NUM_DIGITS-1:0] r_an_n;

   logic                  w_scan_tc;
   bcd_digit_t            w_digit;
   logic [NUM_DIGITS-1:0] w_an_n;

   assign w_scan_tc = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));

   // Digit select and enable pattern from the current scan index.
   always_comb begin
      w_digit = '0;
      w_an_n  = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_scan_idx == IDX_W'(i)) begin
            w_digit   = i_count_bcd[4*i +: 4];
            w_an_n[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_scan_cnt <= '0;
         r_scan_idx <= '0;
      end else if (w_scan_tc) begin
         r_scan_cnt <= '0;
         if (r_scan_idx == IDX_W'(NUM_DIGITS - 1))
            r_scan_idx <= '0;
         else
            r_scan_idx <= r_scan_idx + IDX_W'(1);
      end else begin
         r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
   end

   // Enable and glyph share one register stage so they always change together.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_an_n  <= ~NUM_DIGITS'(1);
         r_seg_n <= GLYPH_0;
      end else begin
         r_an_n  <= w_an_n;
         r_seg_n <= seg7_decode(w_digit);
      end
   end

   assign o_seg_n = r_seg_n;
   assign o_an_n  = r_an_n;

endmodule

// File: rtl/bcd_counter_display.sv
// -----------------------------------------------------------------------------
// bcd_counter_display
// Four-digit (NUM_DIGITS) decimal up/down event counter fed by single-cycle
// debounced pulses, with a multiplexed seven-segment display driver.
//   global_clock : clock, rising edge
//   reset        : asynchronous active-high reset
//   inc_pulse    : increment command (one event per high cycle)
//   dec_pulse    : decrement command
//   clr_pulse    : clear command, highest priority
//   count_bcd    : registered BCD count, digit 0 in [3:0]
//   overflow     : one-cycle pulse, increment attempted at all-nines
//   underflow    : one-cycle pulse, decrement attempted at zero
//   seg_n        : active-low segments {g,f,e,d,c,b,a}
//   an_n         : active-low digit enables, one-hot-low
// -----------------------------------------------------------------------------
module bcd_counter_display
   import counter_pkg::*;
#(
   parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
   parameter int SCAN_DIV   = 100000,
   parameter bit WRAP       = 1'b1
) (
   input  logic                    global_clock,
   input  logic                    reset,
   input  logic                    inc_pulse,
   input  logic                    dec_pulse,
   input  logic                    clr_pulse,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    overflow,
   output logic                    underflow,
   output logic [6:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n
);

   localparam int                    CW        = 4 * NUM_DIGITS;
   localparam logic [CW-1:0]         ALL_NINES = {NUM_DIGITS{4'h9}};

   logic [CW-1:0] r_count_bcd;
   logic          r_overflow;
   logic          r_underflow;

   logic [CW-1:0] w_next_count;
   logic          w_overflow;
   logic          w_underflow;

   // Ripple carry through the digits; all-nines naturally rolls to zero.
   function automatic logic [CW-1:0] bcd_increment(input logic [CW-1:0] v);
      logic [CW-1:0] res;
      logic          carry;
      bcd_digit_t    d;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = v[4*i +: 4];
         if (carry) begin
            if (d == 4'd9) begin
               res[4*i +: 4] = 4'd0;
            end else begin
               res[4*i +: 4] = d + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   // Ripple borrow through the digits; zero naturally rolls to all-nines.
   function automatic logic [CW-1:0] bcd_decrement(input logic [CW-1:0] v);
      logic [CW-1:0] res;
      logic          borrow;
      bcd_digit_t    d;
      res    = v;
      borrow = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               res[4*i +: 4] = 4'd9;
            end else begin
               res[4*i +: 4] = d - 4'd1;
               borrow        = 1'b0;
            end
         end
      end
      return res;
   endfunction

   // Command priority: clear, then inc+dec cancel, then inc, then dec.
   always_comb begin
      w_next_count = r_count_bcd;
      w_overflow   = 1'b0;
      w_underflow  = 1'b0;
      if (clr_pulse) begin
         w_next_count = '0;
      end else if (inc_pulse && dec_pulse) begin
         w_next_count = r_count_bcd;
      end else if (inc_pulse) begin
         if (r_count_bcd == ALL_NINES) begin
            w_overflow   = 1'b1;
            w_next_count = WRAP ? '0 : r_count_bcd;
         end else begin
            w_next_count = bcd_increment(r_count_bcd);
         end
      end else if (dec_pulse) begin
         if (r_count_bcd == '0) begin
            w_underflow  = 1'b1;
            w_next_count = WRAP ? ALL_NINES : r_count_bcd;
         end else begin
            w_next_count = bcd_decrement(r_count_bcd);
         end
      end
   end

   always_ff @(posedge global_clock or posedge reset) begin
      if (reset) begin
         r_count_bcd <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count_bcd <= w_next_count;
         r_overflow  <= w_overflow;
         r_underflow <= w_underflow;
      end
   end

   assign count_bcd = r_count_bcd;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

   seg7_scan #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV)
   ) u_scan (
      .i_clk       (global_clock),
      .i_rst       (reset),
      .i_count_bcd (r_count_bcd),
      .o_seg_n     (seg_n),
      .o_an_n      (an_n)
   );

endmodule

// File: tb/tb_bcd_counter_display.sv
module tb_bcd_counter_display;

   localparam int ND   = 4;
   localparam int SDIV = 4;
   localparam int MAXV = 9999;

   logic global_clock = 1'b0;
   logic reset        = 1'b1;
   logic inc_pulse    = 1'b0;
   logic dec_pulse    = 1'b0;
   logic clr_pulse    = 1'b0;

   // Index 0: WRAP=1 instance, index 1: WRAP=0 instance.
   logic [4*ND-1:0] cnt   [2];
   logic            ovf   [2];
   logic            unf   [2];
   logic [6:0]      seg   [2];
   logic [ND-1:0]   an    [2];

   int   n_tests = 0;
   int   n_fail  = 0;
   int   edges   = 0;

   // Reference model: plain integers 0..9999.
   int   m_cnt [2];
   logic m_ovf [2];
   logic m_unf [2];

   logic [6:0] glyph [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

   always #5 global_clock = ~global_clock;

   always @(posedge global_clock or posedge reset)
      if (reset) edges <= 0;
      else       edges <= edges + 1;

   bcd_counter_display #(.NUM_DIGITS(ND), .SCAN_DIV(SDIV), .WRAP(1'b1)) dut_w (
      .global_clock (global_clock),
      .reset        (reset),
      .inc_pulse    (inc_pulse),
      .dec_pulse    (dec_pulse),
      .clr_pulse    (clr_pulse),
      .count_bcd    (cnt[0]),
      .overflow     (ovf[0]),
      .underflow    (unf[0]),
      .seg_n        (seg[0]),
      .an_n         (an[0])
   );

   bcd_counter_display #(.NUM_DIGITS(ND), .SCAN_DIV(SDIV), .WRAP(1'b0)) dut_s (
      .global_clock (global_clock),
      .reset        (reset),
      .inc_pulse    (inc_pulse),
      .dec_pulse    (dec_pulse),
      .clr_pulse    (clr_pulse),
      .count_bcd    (cnt[1]),
      .overflow     (ovf[1]),
      .underflow    (unf[1]),
      .seg_n        (seg[1]),
      .an_n         (an[1])
   );

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic int digit_of(input int v, input int idx);
      int t;
      t = v;
      for (int i = 0; i < idx; i++) t = t / 10;
      return t % 10;
   endfunction

   // One clock with the given commands; leaves time at 1 unit after the edge.
   task automatic apply(input logic i, input logic d, input logic c);
      inc_pulse = i;
      dec_pulse = d;
      clr_pulse = c;
      @(posedge global_clock);
      #1;
      inc_pulse = 1'b0;
      dec_pulse = 1'b0;
      clr_pulse = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_ovf[k] = 1'b0;
         m_unf[k] = 1'b0;
         if (c) begin
            m_cnt[k] = 0;
         end else if (i && d) begin
            m_cnt[k] = m_cnt[k];
         end else if (i) begin
            if (m_cnt[k] == MAXV) begin
               m_ovf[k] = 1'b1;
               if (k == 0) m_cnt[k] = 0;
            end else begin
               m_cnt[k] = m_cnt[k] + 1;
            end
         end else if (d) begin
            if (m_cnt[k] == 0) begin
               m_unf[k] = 1'b1;
               if (k == 0) m_cnt[k] = MAXV;
            end else begin
               m_cnt[k] = m_cnt[k] - 1;
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge global_clock);
      reset = 1'b1;
      @(negedge global_clock);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0;
         m_ovf[k] = 1'b0;
         m_unf[k] = 1'b0;
      end
      @(posedge global_clock);
      #1;
   endtask

   task automatic test_reset();
      @(negedge global_clock);
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0000 || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_count[%0d]: got cnt=%h ovf=%b unf=%b, want 0000 0 0", k, cnt[k], ovf[k], unf[k]);
         end
         n_tests++;
         if (an[k] !== 4'b1110 || seg[k] !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_display[%0d]: got an=%b seg=%b, want 1110 1000000", k, an[k], seg[k]);
         end
      end
      do_reset();
   endtask

   task automatic test_count();
      apply(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 12; n++) apply(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0012 || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL count_up12[%0d]: got %h ovf=%b unf=%b, want 0012 0 0", k, cnt[k], ovf[k], unf[k]);
         end
      end
      for (int n = 0; n < 3; n++) apply(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0009 || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL count_down3[%0d]: got %h ovf=%b unf=%b, want 0009 0 0", k, cnt[k], ovf[k], unf[k]);
         end
      end
   endtask

   task automatic test_wrap_overflow();
      apply(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < MAXV; n++) apply(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h9999) begin
            n_fail++;
            $display("FAIL load_9999[%0d]: got %h, want 9999", k, cnt[k]);
         end
      end
      apply(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== to_bcd(m_cnt[k]) || ovf[k] !== 1'b1 || unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow[%0d]: got %h ovf=%b unf=%b, want %h 1 0", k, cnt[k], ovf[k], unf[k], to_bcd(m_cnt[k]));
         end
      end
      apply(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== to_bcd(m_cnt[k]) || ovf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_oneshot[%0d]: got %h ovf=%b, want %h 0", k, cnt[k], ovf[k], to_bcd(m_cnt[k]));
         end
      end
      apply(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== to_bcd(m_cnt[k]) || unf[k] !== m_unf[k] || ovf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_after_ovf[%0d]: got %h unf=%b, want %h %b", k, cnt[k], unf[k], to_bcd(m_cnt[k]), m_unf[k]);
         end
      end
   endtask

   task automatic test_underflow();
      apply(1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0000 || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_at_zero[%0d]: got %h ovf=%b unf=%b, want 0000 0 0", k, cnt[k], ovf[k], unf[k]);
         end
      end
      apply(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (cnt[0] !== 16'h9999 || unf[0] !== 1'b1 || ovf[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL underflow_wrap: got %h unf=%b ovf=%b, want 9999 1 0", cnt[0], unf[0], ovf[0]);
      end
      n_tests++;
      if (cnt[1] !== 16'h0000 || unf[1] !== 1'b1 || ovf[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL underflow_sat: got %h unf=%b ovf=%b, want 0000 1 0", cnt[1], unf[1], ovf[1]);
      end
      apply(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL underflow_oneshot[%0d]: got unf=%b, want 0", k, unf[k]);
         end
      end
   endtask

   task automatic test_priority();
      apply(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 100; n++) apply(1'b1, 1'b0, 1'b0);
      apply(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0100 || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_dec_cancel[%0d]: got %h ovf=%b unf=%b, want 0100 0 0", k, cnt[k], ovf[k], unf[k]);
         end
      end
      apply(1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0000 || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_clr[%0d]: got %h ovf=%b unf=%b, want 0000 0 0", k, cnt[k], ovf[k], unf[k]);
         end
      end
      for (int n = 0; n < 1000; n++) apply(1'b1, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0999 || ovf[k] !== 1'b0 || unf[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_chain[%0d]: got %h ovf=%b unf=%b, want 0999 0 0", k, cnt[k], ovf[k], unf[k]);
         end
      end
   endtask

   task automatic test_random();
      logic i, d, c;
      int r;
      int bad;
      apply(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 2; k++) begin
         bad = 0;
         n_tests++;
         if (cnt[k] !== 16'h0000) begin
            n_fail++;
            $display("FAIL random_start[%0d]: got %h, want 0000", k, cnt[k]);
         end
      end
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 15));
         i = (r < 6) || (r == 12);
         d = (r >= 6 && r < 11) || (r == 12) || (r == 13);
         c = (r == 15);
         apply(i, d, c);
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (cnt[k] !== to_bcd(m_cnt[k]) || ovf[k] !== m_ovf[k] || unf[k] !== m_unf[k]) begin
               n_fail++;
               $display("FAIL random[%0d] step %0d: got %h ovf=%b unf=%b, want %h %b %b",
                        k, n, cnt[k], ovf[k], unf[k], to_bcd(m_cnt[k]), m_ovf[k], m_unf[k]);
            end
         end
      end
   endtask

   task automatic test_scan();
      int idx;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      do_reset();
      for (int n = 0; n < 1234; n++) apply(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 16 && ((edges - 1) % 16) != 15; n++) apply(1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 16; j++) begin
         apply(1'b0, 1'b0, 1'b0);
         idx     = j / 4;
         exp_an  = ~(4'b0001 << idx);
         exp_seg = glyph[digit_of(1234, idx)];
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (an[k] !== exp_an || seg[k] !== exp_seg) begin
               n_fail++;
               $display("FAIL scan[%0d] cycle %0d: got an=%b seg=%b, want %b %b", k, j, an[k], seg[k], exp_an, exp_seg);
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      apply(1'b0, 1'b0, 1'b1);
      for (int n = 0; n < 573; n++) apply(1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 6; n++) apply(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (cnt[0] !== 16'h0573) begin
         n_fail++;
         $display("FAIL preload_0573: got %h, want 0573", cnt[0]);
      end
      inc_pulse = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0000 || ovf[k] !== 1'b0 || unf[k] !== 1'b0 ||
             an[k] !== 4'b1110 || seg[k] !== 7'b1000000) begin
            n_fail++;
            $display("FAIL midframe_reset[%0d]: got cnt=%h ovf=%b unf=%b an=%b seg=%b, want 0000 0 0 1110 1000000",
                     k, cnt[k], ovf[k], unf[k], an[k], seg[k]);
         end
      end
      inc_pulse = 1'b0;
      @(negedge global_clock);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0;
         m_ovf[k] = 1'b0;
         m_unf[k] = 1'b0;
      end
      @(posedge global_clock);
      #1;
      apply(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (cnt[k] !== 16'h0001) begin
            n_fail++;
            $display("FAIL first_after_reset[%0d]: got %h, want 0001", k, cnt[k]);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0;
         m_ovf[k] = 1'b0;
         m_unf[k] = 1'b0;
      end
      test_reset();
      test_count();
      test_wrap_overflow();
      test_underflow();
      test_priority();
      test_random();
      test_scan();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
